// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access sizes and FSM encoding.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store-side enables/replication/alignment check and
// load-side lane shift with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_offset,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lanes,
    output logic            misaligned,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be          = 4'b0000;
        wdata_lanes = '0;
        misaligned  = 1'b0;
        case (st_funct3)
            LSU_B, LSU_BU: begin
                be          = 4'b0001 << st_offset;
                wdata_lanes = {4{wdata[7:0]}};
            end
            LSU_H, LSU_HU: begin
                be          = 4'b0011 << st_offset;
                wdata_lanes = {2{wdata[15:0]}};
                misaligned  = st_offset[0];
            end
            LSU_W: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
                misaligned  = (st_offset != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // The addressed byte/half is moved down to lane 0 before extension.
    always_comb begin
        shifted   = rdata >> {ld_offset, 3'b000};
        rdata_ext = '0;
        case (ld_funct3)
            LSU_B:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  rdata_ext = {24'h0, shifted[7:0]};
            LSU_H:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  rdata_ext = {16'h0, shifted[15:0]};
            LSU_W:   rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one EX-stage memory op, drives a req/gnt + rvalid
// data-memory port and returns extended load data as a one-cycle writeback pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    input  logic            ex_is_load_i,
    input  logic            ex_is_store_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic [4:0]      ex_rd_i,
    output logic            lsu_busy_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misaligned_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output lsu_state_t      dbg_state
);

    // Handshake: dmem_req_o with addr/we/be/wdata is held constant from the
    // cycle it rises until the cycle dmem_gnt_i is seen high; dmem_rvalid_i
    // is only honoured in WAIT, which starts the cycle after the grant.

    lsu_state_t      state;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;
    logic [4:0]      rd_q;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_misaligned;
    logic            accept;

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3   (ex_funct3_i),
        .st_offset   (ex_addr_i[1:0]),
        .wdata       (ex_wdata_i),
        .be          (al_be),
        .wdata_lanes (al_wdata),
        .misaligned  (al_misaligned),
        .ld_funct3   (funct3_q),
        .ld_offset   (offset_q),
        .rdata       (dmem_rdata_i),
        .rdata_ext   (al_rdata)
    );

    assign accept     = ex_valid_i && (ex_is_load_i || ex_is_store_i);
    assign lsu_busy_o = (state != ST_IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            rd_q         <= 5'd0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= 5'd0;
            wb_data_o    <= '0;
            misaligned_o <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= '0;
        end else begin
            wb_valid_o   <= 1'b0;
            misaligned_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (al_misaligned) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            state        <= ST_REQ;
                            dmem_req_o   <= 1'b1;
                            // A store flag wins when both load and store are flagged.
                            dmem_we_o    <= ex_is_store_i;
                            dmem_addr_o  <= {ex_addr_i[XLEN-1:2], 2'b00};
                            dmem_be_o    <= al_be;
                            dmem_wdata_o <= al_wdata;
                            funct3_q     <= ex_funct3_i;
                            offset_q     <= ex_addr_i[1:0];
                            rd_q         <= ex_rd_i;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        state      <= dmem_we_o ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_data_o  <= al_rdata;
                        wb_rd_o    <= rd_q;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single transactions with immediate
// grant/rvalid, plus hand sequences for delayed handshakes and reset.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        busy, wb_valid, misaligned, dmem_req, dmem_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    lsu_state_t  state;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] last_wb_data = '0;
    logic [4:0]  last_wb_rd = '0;

    lsu #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_is_store_i(ex_is_store),
        .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
        .lsu_busy_o(busy), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .misaligned_o(misaligned), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .dbg_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input logic mis, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic [31:0] e_wb);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.rdata = rdata; v.mis = mis; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_wb = e_wb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    // One table entry: accept, immediate grant, and for loads rvalid right after.
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        drive_op(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
        if (v.mis) begin
            chk($sformatf("v%0d_mis_pulse", i), {31'b0, misaligned}, 32'd1);
            chk($sformatf("v%0d_mis_noreq", i), {31'b0, dmem_req}, 32'd0);
            chk($sformatf("v%0d_mis_busy", i), {31'b0, busy}, 32'd0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("v%0d_mis_drop", i), {30'b0, misaligned, dmem_req}, 32'd0);
            return;
        end
        chk($sformatf("v%0d_req", i), {30'b0, dmem_req, busy}, 32'd3);
        chk($sformatf("v%0d_addr", i), dmem_addr, v.e_addr);
        chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, v.e_be});
        chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, v.st});
        if (v.st) chk($sformatf("v%0d_wdata", i), dmem_wdata, v.e_wdata);
        dmem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        dmem_gnt = 1'b0;
        chk($sformatf("v%0d_req_drop", i), {31'b0, dmem_req}, 32'd0);
        if (v.st) begin
            chk($sformatf("v%0d_st_done", i), {30'b0, busy, wb_valid}, 32'd0);
            chk($sformatf("v%0d_wb_hold", i), wb_data, last_wb_data);
            return;
        end
        chk($sformatf("v%0d_wait_busy", i), {30'b0, busy, wb_valid}, 32'd2);
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(posedge clk); @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A5A5A;
        chk($sformatf("v%0d_wb_valid", i), {30'b0, wb_valid, busy}, 32'd2);
        chk($sformatf("v%0d_wb_data", i), wb_data, v.e_wb);
        chk($sformatf("v%0d_wb_rd", i), {27'b0, wb_rd}, {27'b0, v.rd});
        last_wb_data = v.e_wb; last_wb_rd = v.rd;
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d_wb_pulse", i), {31'b0, wb_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, 1, LSU_W,  32'h100, 32'hAABBCCDD, 0, 0, 0, 32'h100, 4'b1111, 32'hAABBCCDD, 0);
        vecs[1]  = mk(0, 1, LSU_B,  32'h203, 32'h123456EF, 0, 0, 0, 32'h200, 4'b1000, 32'hEFEFEFEF, 0);
        vecs[2]  = mk(0, 1, LSU_H,  32'h102, 32'hCAFEBEEF, 0, 0, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0);
        vecs[3]  = mk(1, 0, LSU_B,  32'h201, 0, 5, 32'h00008000, 0, 32'h200, 4'b0010, 0, 32'hFFFFFF80);
        vecs[4]  = mk(0, 1, LSU_B,  32'h000, 32'h00000011, 0, 0, 0, 32'h000, 4'b0001, 32'h11111111, 0);
        vecs[5]  = mk(1, 0, LSU_BU, 32'h201, 0, 6, 32'h00008000, 0, 32'h200, 4'b0010, 0, 32'h00000080);
        vecs[6]  = mk(1, 0, LSU_HU, 32'h202, 0, 7, 32'hBEEF0000, 0, 32'h200, 4'b1100, 0, 32'h0000BEEF);
        vecs[7]  = mk(1, 0, LSU_H,  32'h202, 0, 8, 32'h80010000, 0, 32'h200, 4'b1100, 0, 32'hFFFF8001);
        vecs[8]  = mk(1, 0, LSU_W,  32'h104, 0, 9, 32'h12345678, 0, 32'h104, 4'b1111, 0, 32'h12345678);
        vecs[9]  = mk(1, 0, LSU_W,  32'h102, 0, 1, 0, 1, 0, 0, 0, 0);
        vecs[10] = mk(1, 0, LSU_H,  32'h101, 0, 1, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 3'b011, 32'h100, 0, 1, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 1, LSU_W,  32'h300, 32'h11223344, 3, 0, 0, 32'h300, 4'b1111, 32'h11223344, 0);
        vecs[13] = mk(1, 0, LSU_B,  32'h203, 0, 10, 32'h7F000000, 0, 32'h200, 4'b1000, 0, 32'h0000007F);

        // Reset state.
        #3;
        chk("rst_ctrl", {28'b0, busy, wb_valid, misaligned, dmem_req}, 32'd0);
        chk("rst_data", wb_data | dmem_addr | dmem_wdata | {23'b0, dmem_be, wb_rd}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i);

        // Neither load nor store: ignored.
        @(negedge clk);
        drive_op(1'b0, 1'b0, LSU_W, 32'h100, 32'h0, 5'd4);
        chk("nop_ignored", {29'b0, dmem_req, busy, misaligned}, 32'd0);

        // Stray rvalid in IDLE is ignored.
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("idle_rvalid_ignored", {31'b0, wb_valid}, 32'd0);
        chk("idle_rvalid_hold", wb_data, last_wb_data);

        // LW with grant delayed 3 cycles and rvalid delayed 2 cycles.
        drive_op(1'b1, 1'b0, LSU_W, 32'h108, 32'h0, 5'd12);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dly_req_%0d", k), {30'b0, dmem_req, dmem_we}, 32'd2);
            chk($sformatf("dly_addr_%0d", k), dmem_addr, 32'h108);
            chk($sformatf("dly_be_%0d", k), {28'b0, dmem_be}, 32'hF);
            if (k == 3) dmem_gnt = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        dmem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dly_wait_%0d", k), {29'b0, busy, wb_valid, dmem_req}, 32'd4);
            @(posedge clk); @(negedge clk);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("dly_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("dly_wb_data", wb_data, 32'hDEADBEEF);
        chk("dly_wb_rd", {27'b0, wb_rd}, 32'd12);
        @(posedge clk); @(negedge clk);
        chk("dly_wb_single", {30'b0, wb_valid, busy}, 32'd0);
        chk("dly_wb_hold", wb_data, 32'hDEADBEEF);

        // Reset while in WAIT, then a late rvalid.
        drive_op(1'b1, 1'b0, LSU_W, 32'h10C, 32'h0, 5'd13);
        dmem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rstw_in_wait", {30'b0, state}, {30'b0, ST_WAIT});
        rst_n = 1'b0;
        #1;
        chk("rstw_async", {27'b0, busy, wb_valid, misaligned, dmem_req, dmem_we}, 32'd0);
        chk("rstw_data", wb_data | dmem_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rstw_no_wb", {31'b0, wb_valid}, 32'd0);
        chk("rstw_idle", {29'b0, busy, state}, {29'b0, 1'b0, ST_IDLE});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
